// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge detection, run/stop/clear FSM,
// 100 Hz tick prescaler, and registered counter/display control outputs.
module stopwatch_ctrl #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_FREQ = 100
) (
  input  logic       clk_i,
  input  logic       reset_i,        // synchronous, active-low
  input  logic       btn_run_stop_i,
  input  logic       btn_clear_i,
  input  logic       btn_mode_i,
  input  logic       btn_lap_i,
  output logic       tick_o,
  output logic       enable_o,
  output logic       clear_o,
  output logic       sel_o,
  output logic       lap_hold_o,
  output logic [1:0] state_o
);

  localparam int DIV   = CLK_FREQ / TICK_FREQ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10,
    S_CLR  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       btn_prev_q;
  logic [3:0]       btn_now;
  logic [3:0]       btn_edge;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic             enable_q, enable_d;
  logic             clear_q, clear_d;
  logic             sel_q, sel_d;
  logic             lap_q, lap_d;
  logic             run_e, clr_e, mode_e, lap_e;

  assign btn_now  = {btn_lap_i, btn_mode_i, btn_clear_i, btn_run_stop_i};
  assign btn_edge = btn_now & ~btn_prev_q;
  assign run_e    = btn_edge[0];
  assign clr_e    = btn_edge[1];
  assign mode_e   = btn_edge[2];
  assign lap_e    = btn_edge[3];

  // Previous-value registers track the buttons even in reset, so a button
  // held through reset does not look like a fresh press afterwards.
  always_ff @(posedge clk_i) begin
    btn_prev_q <= btn_now;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; in STOP a clear press beats a run press.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (run_e) state_d = S_RUN;
      S_RUN:  if (run_e) state_d = S_STOP;
      S_STOP: begin
        if (clr_e)      state_d = S_CLR;
        else if (run_e) state_d = S_RUN;
      end
      S_CLR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values, decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    enable_d  = (state_d == S_RUN);
    clear_d   = (state_d == S_CLR);
    sel_d     = sel_q ^ mode_e;
    lap_d     = lap_q;
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;

    if (state_q == S_RUN && lap_e)       lap_d = ~lap_q;
    else if (state_q == S_STOP && lap_e) lap_d = 1'b0;
    if (state_d == S_CLR)                lap_d = 1'b0;

    // Prescaler holds in STOP so a pause keeps the partial tick period.
    if (state_q == S_RUN) begin
      if (div_cnt_q == CNT_LAST) begin
        div_cnt_d = '0;
        tick_d    = (state_d == S_RUN);
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
    end else if (state_q == S_IDLE || state_d == S_CLR) begin
      div_cnt_d = '0;
    end
  end

  // Registered outputs and prescaler.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      enable_q  <= 1'b0;
      clear_q   <= 1'b0;
      sel_q     <= 1'b0;
      lap_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      enable_q  <= enable_d;
      clear_q   <= clear_d;
      sel_q     <= sel_d;
      lap_q     <= lap_d;
    end
  end

  assign tick_o     = tick_q;
  assign enable_o   = enable_q;
  assign clear_o    = clear_q;
  assign sel_o      = sel_q;
  assign lap_hold_o = lap_q;
  assign state_o    = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch counter chain. Converts debounced user buttons into the run/stop/clear state machine and generates the 100 Hz counting tick, counter `enable`, one-cycle counter `clear`, display-mode `sel` (`run_md`) and a lap-hold flag that freezes the displayed value. It sits between the button debouncers and the stopwatch counter/display path, and is the only driver of those counter control inputs.

## Interface

- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `TICK_FREQ`, default 100: tick rate in Hz.
  - DIV = CLK_FREQ/TICK_FREQ.
  - CLK_FREQ must be an exact multiple of TICK_FREQ, and DIV ≥ 2.

- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: reset, synchronous and active-low.
- `btn_run_stop` in 1: debounced, synchronous level input.
- `btn_clear` in 1: debounced, synchronous level input.
- `btn_mode` in 1: debounced, synchronous level input.
- `btn_lap` in 1: debounced, synchronous level input.
- `tick` out 1: one-cycle pulse at TICK_FREQ, produced only while running.
- `enable` out 1: counter enable.
- `clear` out 1: one-cycle counter clear.
- `sel` out 1: display mode.
  - 0 = sec/centisec.
  - 1 = hour/min.
- `lap_hold` out 1: display freeze request.
- `state` out 2: current FSM state, for debug and display.

## Operation

- **Edge detection:** each button has a previous-value register. An action occurs when the button is 1 and its previous value is 0.
  - During reset, the previous-value registers load the current button levels, so a button held through reset produces no action.
- **States:** IDLE=2'b00, RUN=2'b01, STOP=2'b10, CLR=2'b11.
- **Transitions:**
  - IDLE: run edge → RUN. Clear and lap edges are ignored.
  - RUN: run edge → STOP. Clear edge is ignored. Lap edge toggles `lap_hold`.
  - STOP: clear edge → CLR. Otherwise, run edge → RUN. Lap edge forces `lap_hold`=0.
  - CLR: unconditionally → IDLE on the next edge. All button edges in this cycle are ignored except mode.
- **Simultaneous edges:**
  - In STOP, clear has priority over run.
  - In RUN, run and lap together → STOP, and `lap_hold` still toggles.
- **Outputs** are registered (Moore style from the next-state):
  - `enable` = (state==RUN).
  - `clear` = (state==CLR).
  - `lap_hold` is forced to 0 on entry to CLR.
- **`sel`:** toggles on every mode edge in any state. It is not affected by CLR.
- **Prescaler:**
  - `div_cnt` is $clog2(DIV) bits wide.
  - It increments only while state==RUN, wrapping from DIV-1 to 0.
  - It holds its value in STOP, so the fractional tick period is preserved across pause and resume.
  - It is zeroed on entry to CLR and in IDLE.
- **`tick`:** registered. It is 1 for exactly the cycle after `div_cnt` wraps DIV-1→0, and only if still in RUN.
  - If RUN is left in the same cycle as a wrap, no tick is issued.
- **Reset values:**
  - state=IDLE.
  - `enable`=0, `clear`=0, `tick`=0, `sel`=0, `lap_hold`=0.
  - `div_cnt`=0.
- **Reset mid-operation:** reset overrides everything on the next edge.
  - A pending CLR pulse is dropped.
  - The counter chain is cleared by its own reset.

## Timing

- **Button latency:** a button rising at the input and sampled at edge k causes the state and outputs to update at edge k. They are visible one cycle after the input change.
- **`clear`:** high for exactly one cycle, then IDLE.
  - Stop → clear press → `clear` high at edge k, IDLE at k+1.
- **First tick:** after entering RUN from IDLE, `enable` rises at edge k and the first `tick` is high during cycle k+DIV. Subsequent ticks follow every DIV cycles.
- **Resume:** if paused with `div_cnt`=m, the next tick occurs DIV−m cycles after RUN is re-entered.
- **Tick/enable relationship:** `tick` is never high while `enable` is low.

## Test plan

Bench parameters: CLK_FREQ=1000, TICK_FREQ=100, so DIV=10.

- **Reset with held button:** assert `reset`=0 for 3 cycles with `btn_run_stop` held at 1, then release reset and hold for 20 cycles → state=IDLE, all outputs 0, no tick.
- **Run and tick cadence:** pulse `btn_run_stop` → `enable`=1 and state=01 next cycle. First `tick` arrives 10 cycles after `enable` rises, then every 10 cycles. After 5 ticks, press run again → state=10, `enable`=0, no further ticks.
- **Pause preserves prescaler:** stop with `div_cnt`=4, wait 50 cycles, resume → next tick exactly 6 cycles after `enable` rises.
- **Clear behaviour:**
  - In STOP, press run and clear in the same cycle → `clear`=1 for one cycle, then IDLE, `div_cnt`=0, `lap_hold`=0.
  - Clear pressed in RUN → no effect.
- **Lap and mode:**
  - In RUN, lap edge → `lap_hold`=1, second lap edge → `lap_hold`=0.
  - Lap edge in STOP with `lap_hold`=1 → `lap_hold`=0.
  - Mode edges in IDLE, RUN, STOP and CLR each toggle `sel`, and `sel` survives CLR.
- **Reset mid-run:** apply reset during RUN at `div_cnt`=7 → next cycle state=IDLE, `enable`=0, `tick`=0, `div_cnt`=0, `sel`=0.
